ram_ctrl: RTL and testbench
===========================

Name: ram_ctrl

Overview:
Sequencing front-end for the CPU's latch-based word storage. Accepts one read or write request at a time over a valid/ready handshake and holds it for a fixed multi-cycle access window. Commits writes at the end of that window and returns a one-cycle response carrying read data. Sits between the CPU memory port and the storage array; it models the array internally as 2^ADDR_W words of DATA_W bits.

Parameters:
ADDR_W, 4, address width; storage depth = 2^ADDR_W words
DATA_W, 8, data word width in bits
ACCESS_CYC, 2, cycles spent in ACCESS state per request; legal range 1..15

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
req_valid  input  1  request present
req_ready  output  1  controller can accept a request this cycle
req_we  input  1  1 = write, 0 = read; sampled at accept
req_addr  input  ADDR_W  word address; sampled at accept
req_wdata  input  DATA_W  write data; sampled at accept
rsp_valid  output  1  one-cycle pulse: request complete
rsp_rdata  output  DATA_W  read data, valid while rsp_valid=1 for reads
busy  output  1  1 whenever the FSM is not in IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge): FSM goes to IDLE (or CLEAR, see Optional Feature); access counter cleared; rsp_valid=0; rsp_rdata=0; latched request registers cleared. Outputs after reset: req_ready=1 (IDLE), busy=0.
- Reset overrides every other event in the same cycle, including an accept.
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid=1, latch req_we, req_addr and req_wdata, load the counter with ACCESS_CYC-1, and go to ACCESS. With req_valid=0, stay in IDLE.
- ACCESS: req_ready=0. Decrement the counter each cycle. When the counter is 0, do the following and go to RESP:
  - for a write, write the latched wdata to mem[latched addr];
  - for a read, register mem[latched addr] into rsp_rdata.
- RESP: rsp_valid=1 for exactly this cycle, then unconditionally return to IDLE. rsp_rdata holds its value until the next read completes; writes leave rsp_rdata unchanged.
- Latency: accept at edge T; rsp_valid is high in cycle T+ACCESS_CYC+1. Throughput is one request per ACCESS_CYC+2 cycles.
- The earliest next accept is in the cycle after RESP. req_valid held high during ACCESS/RESP is ignored, not queued.
- Request inputs may change freely after accept; only latched copies are used.
- Read after write to the same address returns the new data, because the write commits before the next accept.
- Address wrap: none needed; every ADDR_W value is a valid word.
- Reset mid-ACCESS: the request is aborted, no write is committed, and no rsp_valid is issued. A write already committed in a prior cycle persists.
- mem is not touched by reset unless RAM_CLEAR_EN is defined.

Optional Feature:
Macro RAM_CLEAR_EN.
- Defined: reset enters a CLEAR state instead of IDLE. CLEAR writes 0 to mem[0..2^ADDR_W-1], one word per cycle with an incrementing index, then goes to IDLE after the last word. During CLEAR, req_ready=0 and busy=1. The first accept is possible 2^ADDR_W cycles after reset deasserts. Reset during CLEAR restarts the sweep at index 0.
- Not defined: no CLEAR state; contents are X at power-up and retained across reset.

Test Plan:
- Reset, then hold rst_n=1 and idle -> req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0 (with RAM_CLEAR_EN: req_ready=0 for 16 cycles first, then 1).
- Write addr 3 data 0xA5, then read addr 3 (default params) -> write rsp_valid at T+3; read rsp_valid exactly 3 cycles after its accept with rsp_rdata=0xA5.
- Hold req_valid=1 continuously with reads of addrs 0,1,2 after writing 0x11,0x22,0x33 -> accepts spaced 4 cycles apart; responses 0x11,0x22,0x33 in order; no request lost or duplicated.
- Write addr 15 data 0xFF, pull rst_n low during ACCESS, release, then read addr 15 -> no rsp_valid for the aborted write; read returns the prior value (0x00 if RAM_CLEAR_EN, else unchanged).
- Change req_addr/req_wdata every cycle during ACCESS after accepting write addr 5 data 0x3C -> mem[5]=0x3C only; a subsequent read of the other addresses shows them unchanged.
- ACCESS_CYC=1: a write then a read to addr 7 with 0x5A -> rsp_valid at T+2; read returns 0x5A; busy high exactly 2 cycles per request.

Source files
------------

// File: rtl/ram_ctrl.sv
// Request sequencer for the CPU word store: one access at a time,
// fixed access window, one-cycle response. Optional RAM_CLEAR_EN.
module ram_ctrl #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int ACCESS_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

`ifdef RAM_CLEAR_EN
  typedef enum logic [1:0] {
    IDLE, ACCESS, RESP, CLEAR
  } state_t;
  localparam state_t RST_STATE = CLEAR;
`else
  typedef enum logic [1:0] {
    IDLE, ACCESS, RESP
  } state_t;
  localparam state_t RST_STATE = IDLE;
`endif

  state_t state, state_nx;

  logic [3:0]        cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              accept;
  logic              commit;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

`ifdef RAM_CLEAR_EN
  logic [ADDR_W-1:0] clr_idx;
`endif

  // State, counter, latched request and read-data registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RST_STATE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_rdata <= '0;
`ifdef RAM_CLEAR_EN
      clr_idx   <= '0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        cnt       <= 4'(ACCESS_CYC - 1);
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !lat_we) begin
        rsp_rdata <= mem[lat_addr];
      end
`ifdef RAM_CLEAR_EN
      if (state == CLEAR) begin
        clr_idx <= clr_idx + 1'b1;
      end
`endif
    end
  end

  // Storage array; reset blocks any write in that cycle
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Next state, handshake outputs and array write strobe
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    commit    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = lat_addr;
    mem_wdata = lat_wdata;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          accept   = 1'b1;
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          commit   = 1'b1;
          mem_we   = lat_we;
          state_nx = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nx  = IDLE;
      end
`ifdef RAM_CLEAR_EN
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx;
        mem_wdata = '0;
        if (clr_idx == '1) begin
          state_nx = IDLE;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: table vectors with a response
// scoreboard, plus hand sequences for reset abort and ACCESS_CYC=1.
module tb_ram_ctrl;

  localparam int ACC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;

  logic       v1;
  logic       r1;
  logic       we1;
  logic [3:0] a1;
  logic [7:0] d1;
  logic       rv1;
  logic [7:0] rd1;
  logic       b1;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int cyc      = 0;

  logic [7:0] q[$];
  logic [7:0] last_rd;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } vec_t;

  vec_t tbl[9];

  ram_ctrl #(.ADDR_W(4), .DATA_W(8), .ACCESS_CYC(ACC)) u0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy)
  );

  ram_ctrl #(.ADDR_W(4), .DATA_W(8), .ACCESS_CYC(1)) u1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (v1),
    .req_ready (r1),
    .req_we    (we1),
    .req_addr  (a1),
    .req_wdata (d1),
    .rsp_valid (rv1),
    .rsp_rdata (rd1),
    .busy      (b1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every response must match the oldest pending entry
  always @(posedge clk) begin
    #1;
    if (rsp_valid) begin
      vec_cnt++;
      if (q.size() == 0) begin
        miss_cnt++;
        $display("FAIL spurious_rsp: got rsp_valid=1 expected 0");
      end else begin
        logic [7:0] e;
        e = q.pop_front();
        if (rsp_rdata !== e) begin
          miss_cnt++;
          $display("FAIL rsp_rdata: got %0h expected %0h",
                   rsp_rdata, e);
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic do_req(input logic we, input logic [3:0] a,
                        input logic [7:0] d, input logic [7:0] rexp,
                        input bit jig);
    int n;
    logic [7:0] e;
    wait_ready();
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    e = we ? last_rd : rexp;
    last_rd = e;
    @(posedge clk); #1;
    q.push_back(e);
    if (!jig) req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      if (jig) begin
        req_addr  = 4'($urandom);
        req_wdata = 8'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    chk($sformatf("latency_a%0d", a), n, ACC);
  endtask

  task automatic do_req1(input logic we, input logic [3:0] a,
                         input logic [7:0] d, input logic [7:0] rexp);
    int n, lat, nb;
    n = 0;
    while (!r1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("u1_ready", int'(r1), 1);
    v1 = 1'b1; we1 = we; a1 = a; d1 = d;
    @(posedge clk); #1;
    v1 = 1'b0;
    lat = -1;
    nb  = 0;
    for (int k = 0; k < 6; k++) begin
      if (b1) nb++;
      if (rv1 && lat < 0) begin
        lat = k;
        if (!we) chk("u1_rdata", int'(rd1), int'(rexp));
      end
      @(posedge clk); #1;
    end
    chk("u1_latency", lat, 1);
    chk("u1_busy_cycles", nb, 2);
  endtask

  initial begin
    int n;
    int acc_cyc[3];
    logic [7:0] exp15;

    tbl[0] = '{1'b1, 4'd3,  8'hA5, 8'h00};
    tbl[1] = '{1'b0, 4'd3,  8'h00, 8'hA5};
    tbl[2] = '{1'b1, 4'd0,  8'h11, 8'h00};
    tbl[3] = '{1'b1, 4'd1,  8'h22, 8'h00};
    tbl[4] = '{1'b1, 4'd2,  8'h33, 8'h00};
    tbl[5] = '{1'b1, 4'd15, 8'hF0, 8'h00};
    tbl[6] = '{1'b0, 4'd15, 8'h00, 8'hF0};
    tbl[7] = '{1'b1, 4'd9,  8'hC3, 8'h00};
    tbl[8] = '{1'b0, 4'd9,  8'h00, 8'hC3};

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0;
    v1 = 1'b0; we1 = 1'b0; a1 = '0; d1 = '0;
    last_rd = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!req_ready && n < 40);
`ifdef RAM_CLEAR_EN
    chk("ready_after_reset_cycles", n, 16);
`else
    chk("ready_after_reset_cycles", n, 1);
`endif
    chk("reset_busy", int'(busy), 0);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_rdata", int'(rsp_rdata), 0);

`ifdef RAM_CLEAR_EN
    do_req(1'b0, 4'd6, 8'h00, 8'h00, 1'b0);
`endif

    for (int i = 0; i < 9; i++) begin
      do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata,
             tbl[i].rdata, 1'b0);
    end

    // back-to-back reads with req_valid held high
    wait_ready();
    req_valid = 1'b1;
    req_we    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (!req_ready && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      req_addr = 4'(i);
      @(posedge clk); #1;
      acc_cyc[i] = cyc;
      q.push_back(8'h11 * 8'(i + 1));
    end
    req_valid = 1'b0;
    last_rd = 8'h33;
    chk("accept_spacing_1", acc_cyc[1] - acc_cyc[0], ACC + 2);
    chk("accept_spacing_2", acc_cyc[2] - acc_cyc[1], ACC + 2);
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stream_drained", q.size(), 0);

    // inputs wander during ACCESS; only latched copies count
    do_req(1'b1, 4'd5, 8'h3C, 8'h00, 1'b1);
    do_req(1'b0, 4'd5, 8'h00, 8'h3C, 1'b0);
    do_req(1'b0, 4'd3, 8'h00, 8'hA5, 1'b0);
    do_req(1'b0, 4'd0, 8'h00, 8'h11, 1'b0);
    do_req(1'b0, 4'd9, 8'h00, 8'hC3, 1'b0);

    // reset during ACCESS aborts the write
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1;
    req_addr = 4'd15; req_wdata = 8'hFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_rd = 8'h00;
    chk("abort_rsp_rdata", int'(rsp_rdata), 0);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid) n++;
      @(posedge clk); #1;
    end
    chk("abort_no_rsp", n, 0);
`ifdef RAM_CLEAR_EN
    exp15 = 8'h00;
`else
    exp15 = 8'hF0;
`endif
    do_req(1'b0, 4'd15, 8'h00, exp15, 1'b0);

    // ACCESS_CYC=1 instance
    do_req1(1'b1, 4'd7, 8'h5A, 8'h00);
    do_req1(1'b0, 4'd7, 8'h00, 8'h5A);

    chk("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, miss_cnt);
    $finish;
  end

endmodule
